// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and execute-operand selection.
// Optional macro ID_EX_FORWARD_EN enables MEM/WB forwarding; otherwise RAW hazards stall instead.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic [RAW-1:0]  id_rd,
    input  logic [2:0]      id_alu_control,
    input  logic            id_alu_src,
    input  logic [4:0]      id_ctrl,
    input  logic            flush,
    input  logic [RAW-1:0]  mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RAW-1:0]  wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [RAW-1:0]  ex_rd,
    output logic [4:0]      ex_ctrl,
    output logic [2:0]      ex_alu_control,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] ex_store_data
);

    logic [RAW-1:0]  ex_rs1_reg;
    logic [RAW-1:0]  ex_rs2_reg;
    logic [XLEN-1:0] rs1_data_reg;
    logic [XLEN-1:0] rs2_data_reg;
    logic [XLEN-1:0] imm_reg;
    logic            alu_src_reg;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [RAW-1:0]  id_rs [2];
    logic [1:0]      hit_ex;
    logic            load_hazard;
    logic            lu;

    assign id_rs[0] = id_rs1;
    assign id_rs[1] = id_rs2;

    // Per-source-operand match of the decode instruction against the EX destination.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hit_ex
            assign hit_ex[gi] = (ex_rd != '0) && (id_rs[gi] == ex_rd);
        end
    endgenerate

    assign load_hazard = id_valid & ex_valid & ex_ctrl[2] & (|hit_ex);

`ifdef ID_EX_FORWARD_EN
    function automatic logic [XLEN-1:0] fwd_sel(input logic [RAW-1:0]  addr,
                                                input logic [XLEN-1:0] reg_data);
        logic [XLEN-1:0] r;
        r = reg_data;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == addr))
            r = mem_result;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == addr))
            r = wb_result;
        return r;
    endfunction

    assign lu      = load_hazard;
    assign fwd_rs1 = fwd_sel(ex_rs1_reg, rs1_data_reg);
    assign fwd_rs2 = fwd_sel(ex_rs2_reg, rs2_data_reg);
`else
    logic [1:0] hit_mem;
    logic       unused_fwd_inputs;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hit_mem
            assign hit_mem[gi] = (mem_rd != '0) && (id_rs[gi] == mem_rd);
        end
    endgenerate

    // Without forwarding any pending write in EX or MEM must drain first; WB writes
    // the register file before decode reads it, so WB needs no check.
    assign lu = load_hazard
              | (id_valid & ex_valid & ex_ctrl[4] & (|hit_ex))
              | (id_valid & mem_reg_write & (|hit_mem));
    assign fwd_rs1 = rs1_data_reg;
    assign fwd_rs2 = rs2_data_reg;
    assign unused_fwd_inputs = ^{mem_result, wb_rd, wb_reg_write, wb_result,
                                 ex_rs1_reg, ex_rs2_reg};
`endif

    assign stall = lu & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush || lu) begin
            ex_valid       <= 1'b0;
            ex_pc          <= '0;
            ex_rs1_reg     <= '0;
            ex_rs2_reg     <= '0;
            rs1_data_reg   <= '0;
            rs2_data_reg   <= '0;
            imm_reg        <= '0;
            ex_rd          <= '0;
            alu_src_reg    <= 1'b0;
            ex_alu_control <= '0;
            ex_ctrl        <= '0;
        end else begin
            ex_valid       <= id_valid;
            ex_pc          <= id_pc;
            ex_rs1_reg     <= id_rs1;
            ex_rs2_reg     <= id_rs2;
            rs1_data_reg   <= id_rs1_data;
            rs2_data_reg   <= id_rs2_data;
            imm_reg        <= id_imm;
            ex_rd          <= id_rd;
            alu_src_reg    <= id_alu_src;
            ex_alu_control <= id_alu_control;
            ex_ctrl        <= id_valid ? id_ctrl : 5'b0;
        end
    end

    assign alu_a         = fwd_rs1;
    assign alu_b         = alu_src_reg ? imm_reg : fwd_rs2;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow the build's ID_EX_FORWARD_EN setting.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [2:0]  id_alu_control;
    logic        id_alu_src;
    logic [4:0]  id_ctrl;
    logic        flush;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_result;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_ctrl;
    logic [2:0]  ex_alu_control;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] ex_store_data;

    int passed = 0;
    int total  = 0;

    id_ex_stage #(.XLEN(32), .RAW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_ctrl(id_ctrl),
        .flush(flush), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_result(wb_result), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_alu_control(ex_alu_control),
        .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fwd_idle();
        mem_rd = 5'd0; mem_reg_write = 1'b0; mem_result = 32'd0;
        wb_rd = 5'd0;  wb_reg_write = 1'b0;  wb_result = 32'd0;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [2:0] op, input logic src, input logic [4:0] c);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_alu_control = op; id_alu_src = src; id_ctrl = c;
    endtask

    task automatic set_idle();
        set_id(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd0);
        flush = 1'b0;
        fwd_idle();
    endtask

    task automatic test_reset();
        logic [31:0] r;
        $display("txn reset: rst held 2 cycles with random decode fields");
        fwd_idle();
        flush = 1'b0;
        rst = 1'b1;
        r = $urandom;
        set_id(1'b1, $urandom, r[4:0], r[9:5], r[14:10], $urandom, $urandom, $urandom,
               r[17:15], r[18], r[23:19]);
        tick();
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); else passed++;
        total++; if (ex_pc !== 32'd0) $display("FAIL reset_ex_pc: got %h expected 0", ex_pc); else passed++;
        total++; if (ex_rd !== 5'd0) $display("FAIL reset_ex_rd: got %h expected 0", ex_rd); else passed++;
        total++; if (ex_ctrl !== 5'd0) $display("FAIL reset_ex_ctrl: got %b expected 0", ex_ctrl); else passed++;
        total++; if (ex_alu_control !== 3'd0) $display("FAIL reset_alu_control: got %b expected 0", ex_alu_control); else passed++;
        total++; if (alu_a !== 32'd0) $display("FAIL reset_alu_a: got %h expected 0", alu_a); else passed++;
        total++; if (alu_b !== 32'd0) $display("FAIL reset_alu_b: got %h expected 0", alu_b); else passed++;
        total++; if (ex_store_data !== 32'd0) $display("FAIL reset_store_data: got %h expected 0", ex_store_data); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else passed++;
        $display("txn reset release: first edge captures pc 0x40");
        set_id(1'b1, 32'h40, 5'd0, 5'd0, 5'd2, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 5'b10000);
        rst = 1'b0;
        tick();
        total++; if (ex_pc !== 32'h40) $display("FAIL release_ex_pc: got %h expected 40", ex_pc); else passed++;
        total++; if (ex_valid !== 1'b1) $display("FAIL release_ex_valid: got %b expected 1", ex_valid); else passed++;
    endtask

    task automatic test_pass_through();
        $display("txn pass-through: pc 0x100 rs1_data 5 imm 7 alu_src 1 rd 3");
        set_id(1'b1, 32'h100, 5'd1, 5'd4, 5'd3, 32'd5, 32'd9, 32'd7, 3'b000, 1'b1, 5'b10000);
        tick();
        total++; if (alu_a !== 32'd5) $display("FAIL pass_alu_a: got %h expected 5", alu_a); else passed++;
        total++; if (alu_b !== 32'd7) $display("FAIL pass_alu_b: got %h expected 7", alu_b); else passed++;
        total++; if (ex_store_data !== 32'd9) $display("FAIL pass_store_data: got %h expected 9", ex_store_data); else passed++;
        total++; if (ex_rd !== 5'd3) $display("FAIL pass_ex_rd: got %h expected 3", ex_rd); else passed++;
        total++; if (ex_valid !== 1'b1) $display("FAIL pass_ex_valid: got %b expected 1", ex_valid); else passed++;
        total++; if (ex_ctrl !== 5'b10000) $display("FAIL pass_ex_ctrl: got %b expected 10000", ex_ctrl); else passed++;
        $display("txn pass-through: register operand B, alu_control 010");
        set_id(1'b1, 32'h104, 5'd9, 5'd10, 5'd8, 32'd11, 32'd22, 32'd99, 3'b010, 1'b0, 5'b10000);
        tick();
        total++; if (alu_b !== 32'd22) $display("FAIL pass2_alu_b: got %h expected 16", alu_b); else passed++;
        total++; if (ex_alu_control !== 3'b010) $display("FAIL pass2_alu_control: got %b expected 010", ex_alu_control); else passed++;
        total++; if (ex_pc !== 32'h104) $display("FAIL pass2_ex_pc: got %h expected 104", ex_pc); else passed++;
    endtask

    task automatic test_invalid();
        $display("txn invalid decode slot with ctrl 11111");
        set_id(1'b0, 32'h108, 5'd8, 5'd8, 5'd5, 32'd1, 32'd2, 32'd3, 3'b001, 1'b0, 5'b11111);
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL invalid_ex_valid: got %b expected 0", ex_valid); else passed++;
        total++; if (ex_ctrl !== 5'd0) $display("FAIL invalid_ex_ctrl: got %b expected 0", ex_ctrl); else passed++;
        total++; if (ex_pc !== 32'h108) $display("FAIL invalid_ex_pc: got %h expected 108", ex_pc); else passed++;
    endtask

    task automatic test_forward();
        logic [31:0] exp_a;
        logic [31:0] exp_sd;
        $display("txn forward: ex_rs1 = ex_rs2 = 4, MEM and WB both target x4");
        set_id(1'b1, 32'h180, 5'd4, 5'd4, 5'd1, 32'h44, 32'h55, 32'd0, 3'd0, 1'b0, 5'b00000);
        tick();
        set_idle();
        mem_rd = 5'd4; mem_reg_write = 1'b1; mem_result = 32'hAA;
        wb_rd = 5'd4;  wb_reg_write = 1'b1;  wb_result = 32'hBB;
        #1;
`ifdef ID_EX_FORWARD_EN
        exp_a = 32'hAA; exp_sd = 32'hAA;
`else
        exp_a = 32'h44; exp_sd = 32'h55;
`endif
        total++; if (alu_a !== exp_a) $display("FAIL fwd_mem_prio_a: got %h expected %h", alu_a, exp_a); else passed++;
        total++; if (ex_store_data !== exp_sd) $display("FAIL fwd_mem_prio_sd: got %h expected %h", ex_store_data, exp_sd); else passed++;
        mem_reg_write = 1'b0;
        #1;
`ifdef ID_EX_FORWARD_EN
        exp_a = 32'hBB;
`else
        exp_a = 32'h44;
`endif
        total++; if (alu_a !== exp_a) $display("FAIL fwd_wb_a: got %h expected %h", alu_a, exp_a); else passed++;
        mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
        #1;
        total++; if (alu_a !== 32'h44) $display("FAIL fwd_x0_a: got %h expected 44", alu_a); else passed++;
        fwd_idle();
    endtask

    task automatic test_load_use();
        $display("txn load-use: lw x6 in EX, add reads x6");
        set_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd6, 32'h1000, 32'd0, 32'd4, 3'd0, 1'b1, 5'b10100);
        tick();
        set_id(1'b1, 32'h204, 5'd5, 5'd6, 5'd9, 32'h50, 32'h66, 32'd0, 3'd0, 1'b0, 5'b10000);
        #1;
        total++; if (stall !== 1'b1) $display("FAIL lu_stall: got %b expected 1", stall); else passed++;
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble_valid: got %b expected 0", ex_valid); else passed++;
        total++; if (ex_ctrl !== 5'd0) $display("FAIL lu_bubble_ctrl: got %b expected 0", ex_ctrl); else passed++;
        mem_rd = 5'd6; mem_reg_write = 1'b1; mem_result = 32'h1234;
        #1;
`ifdef ID_EX_FORWARD_EN
        total++; if (stall !== 1'b0) $display("FAIL lu_stall_len: got %b expected 0", stall); else passed++;
        tick();
        fwd_idle();
        wb_rd = 5'd6; wb_reg_write = 1'b1; wb_result = 32'h1234;
        #1;
        total++; if (ex_store_data !== 32'h1234) $display("FAIL lu_fwd_rs2: got %h expected 1234", ex_store_data); else passed++;
`else
        total++; if (stall !== 1'b1) $display("FAIL lu_stall_mem: got %b expected 1", stall); else passed++;
        tick();
        fwd_idle();
        wb_rd = 5'd6; wb_reg_write = 1'b1; wb_result = 32'h1234;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL lu_stall_wb: got %b expected 0", stall); else passed++;
        tick();
        fwd_idle();
        #1;
        total++; if (ex_store_data !== 32'h66) $display("FAIL lu_rs2_data: got %h expected 66", ex_store_data); else passed++;
`endif
        total++; if (ex_valid !== 1'b1) $display("FAIL lu_add_valid: got %b expected 1", ex_valid); else passed++;
        total++; if (ex_rd !== 5'd9) $display("FAIL lu_add_rd: got %h expected 9", ex_rd); else passed++;
        total++; if (alu_a !== 32'h50) $display("FAIL lu_add_a: got %h expected 50", alu_a); else passed++;
        set_idle();
    endtask

    task automatic test_flush_vs_stall();
        $display("txn flush with load-use pending");
        set_id(1'b1, 32'h300, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 3'd0, 1'b1, 5'b10100);
        tick();
        set_id(1'b1, 32'h304, 5'd0, 5'd6, 5'd9, 32'h1, 32'h2, 32'd0, 3'd0, 1'b0, 5'b10000);
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall); else passed++;
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", ex_valid); else passed++;
        total++; if (ex_pc !== 32'd0) $display("FAIL flush_pc: got %h expected 0", ex_pc); else passed++;
        set_idle();
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL flush_never_valid: got %b expected 0", ex_valid); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        $display("txn reset during load-use stall");
        set_id(1'b1, 32'h400, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 3'd0, 1'b1, 5'b10100);
        tick();
        set_id(1'b1, 32'h404, 5'd6, 5'd0, 5'd2, 32'h3, 32'h4, 32'd0, 3'd0, 1'b0, 5'b10000);
        #1;
        total++; if (stall !== 1'b1) $display("FAIL rst_mid_pre_stall: got %b expected 1", stall); else passed++;
        rst = 1'b1;
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", ex_valid); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL rst_mid_stall: got %b expected 0", stall); else passed++;
        rst = 1'b0;
        set_idle();
        tick();
    endtask

`ifndef ID_EX_FORWARD_EN
    task automatic test_raw_no_forward();
        $display("txn RAW without forwarding: x7 written in EX, read in decode");
        set_id(1'b1, 32'h500, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 5'b10000);
        tick();
        set_id(1'b1, 32'h504, 5'd7, 5'd0, 5'd2, 32'h77, 32'd0, 32'd0, 3'd0, 1'b0, 5'b10000);
        #1;
        total++; if (stall !== 1'b1) $display("FAIL raw_stall_ex: got %b expected 1", stall); else passed++;
        tick();
        mem_rd = 5'd7; mem_reg_write = 1'b1; mem_result = 32'hEE;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL raw_stall_mem: got %b expected 1", stall); else passed++;
        tick();
        fwd_idle();
        wb_rd = 5'd7; wb_reg_write = 1'b1; wb_result = 32'hEE;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL raw_stall_wb: got %b expected 0", stall); else passed++;
        tick();
        total++; if (ex_pc !== 32'h504) $display("FAIL raw_ex_pc: got %h expected 504", ex_pc); else passed++;
        total++; if (alu_a !== 32'h77) $display("FAIL raw_alu_a: got %h expected 77", alu_a); else passed++;
        set_idle();
    endtask
`endif

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_pass_through();
        test_invalid();
        test_forward();
        test_load_use();
        test_flush_vs_stall();
        test_reset_mid_stall();
`ifndef ID_EX_FORWARD_EN
        test_raw_no_forward();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
